// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the MIPS multi-cycle control slice.
//   OPCODE_WIDTH     : width of the primary opcode field
//   OP_*             : supported primary opcodes
//   state_t          : control FSM states, one per instruction phase
//   ctrl_t           : datapath control word produced by the main decoder
//   is_legal_op()    : 1 when an opcode belongs to the supported set
package mips_multicycle_control_pkg;

  localparam int OPCODE_WIDTH = 6;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  typedef struct packed {
    logic ce;
    logic reg_dst;
    logic reg_write;
    logic alu_src;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_main_decoder.sv
// Main decoder: pure combinational map from (state, latched opcode) to the
// datapath control word.
//   state : current FSM state (registered in the top)
//   op    : latched opcode of the instruction in flight
//   ctrl  : control word; all strobes 0 outside EXEC/MEM/WB except ce in FETCH
module mips_main_decoder
  import mips_multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_WIDTH
) (
  input  state_t              state,
  input  logic [OPCODE_W-1:0] op,
  output ctrl_t               ctrl
);

  logic op_imm;

  // Loads, stores and ADDI all feed the sign-extended immediate to the ALU.
  assign op_imm = (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);

  always_comb begin
    // NOTE: the whole word gets a default before the case so no path leaves a
    // field unassigned; that is what keeps this block free of latches.
    ctrl = '0;
    unique case (state)
      ST_FETCH: ctrl.ce = 1'b1;
      ST_EXEC: begin
        ctrl.alu_src = op_imm;
        ctrl.branch  = (op == OP_BEQ);
      end
      ST_MEM: begin
        ctrl.alu_src   = op_imm;
        ctrl.mem_read  = (op == OP_LW);
        ctrl.mem_write = (op == OP_SW);
      end
      ST_WB: begin
        ctrl.alu_src    = op_imm;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (op == OP_RTYPE);
        ctrl.mem_to_reg = (op == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle main control FSM for the MIPS datapath. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, counts retired instructions and pulses a
// flag when an unsupported opcode is dropped.
//   c_clk, c_rst   : clock, asynchronous active-high reset
//   c_i_run        : keep issuing instructions (sampled in IDLE and at retire)
//   c_i_opcode     : opcode from the decoder stage, sampled in DECODE
//   c_o_ce         : instruction fetch enable (FETCH only)
//   c_o_RegDst .. c_o_MemtoReg : datapath control strobes
//   c_o_busy       : state is not IDLE
//   c_o_illegal    : one-cycle pulse after an unsupported opcode is dropped
//   c_o_retired    : retired-instruction count, wraps modulo 2^CNT_WIDTH
// All outputs come from registered state only; c_i_* never reach c_o_*
// combinationally.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int OPCODE_W  = OPCODE_WIDTH,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 c_clk,
  input  logic                 c_rst,
  input  logic                 c_i_run,
  input  logic [OPCODE_W-1:0]  c_i_opcode,
  output logic                 c_o_ce,
  output logic                 c_o_RegDst,
  output logic                 c_o_RegWrite,
  output logic                 c_o_ALUSrc,
  output logic                 c_o_Branch,
  output logic                 c_o_MemRead,
  output logic                 c_o_MemWrite,
  output logic                 c_o_MemtoReg,
  output logic                 c_o_busy,
  output logic                 c_o_illegal,
  output logic [CNT_WIDTH-1:0] c_o_retired
);

  state_t               state_q, state_d;
  logic [OPCODE_W-1:0]  op_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 retire;
  logic                 decode_legal;
  ctrl_t                ctrl;

  // Legality is judged on the live opcode while in DECODE, because op_q only
  // takes that value at the end of the same cycle.
  assign decode_legal = is_legal_op(c_i_opcode);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE:   if (c_i_run) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (decode_legal) state_d = ST_EXEC;
        else              state_d = c_i_run ? ST_FETCH : ST_IDLE;
      end
      ST_EXEC: begin
        if (op_q == OP_BEQ)                        retire  = 1'b1;
        else if ((op_q == OP_LW) || (op_q == OP_SW)) state_d = ST_MEM;
        else                                       state_d = ST_WB;
      end
      ST_MEM: begin
        if (op_q == OP_LW) state_d = ST_WB;
        else               retire  = 1'b1;
      end
      ST_WB:   retire  = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    // Every retiring phase shares the same continuation rule.
    if (retire) state_d = c_i_run ? ST_FETCH : ST_IDLE;
  end

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; blocking assignments would chain them.
  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      // NOTE: op_q is reset too, even though it is rewritten before use, so
      // the decoder output is fully defined from reset without relying on
      // the IDLE state masking it.
      state_q   <= ST_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      if (state_q == ST_DECODE) op_q <= c_i_opcode;
      // DECODE never repeats on consecutive cycles, so this is a lone pulse.
      illegal_q <= (state_q == ST_DECODE) && !decode_legal;
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  mips_main_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_main_decoder (
    .state (state_q),
    .op    (op_q),
    .ctrl  (ctrl)
  );

  assign c_o_ce       = ctrl.ce;
  assign c_o_RegDst   = ctrl.reg_dst;
  assign c_o_RegWrite = ctrl.reg_write;
  assign c_o_ALUSrc   = ctrl.alu_src;
  assign c_o_Branch   = ctrl.branch;
  assign c_o_MemRead  = ctrl.mem_read;
  assign c_o_MemWrite = ctrl.mem_write;
  assign c_o_MemtoReg = ctrl.mem_to_reg;
  assign c_o_busy     = (state_q != ST_IDLE);
  assign c_o_illegal  = illegal_q;
  assign c_o_retired  = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control. A program of instructions
// (directed, then random) is turned into a per-cycle schedule by a reference
// model built from instruction latencies and phase rules. A driver applies
// each cycle's inputs and pushes that cycle's expected outputs into a
// scoreboard queue; a monitor pops and compares on the falling edge.
// Two instances share the stimulus: a 4-bit counter (to see wrap) and the
// default 32-bit counter.
module tb_mips_multicycle_control;

  localparam logic [5:0] T_R    = 6'h00;
  localparam logic [5:0] T_LW   = 6'h23;
  localparam logic [5:0] T_SW   = 6'h2B;
  localparam logic [5:0] T_BEQ  = 6'h04;
  localparam logic [5:0] T_ADDI = 6'h08;

  typedef struct packed {
    logic ce;
    logic reg_dst;
    logic reg_write;
    logic alu_src;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic busy;
    logic illegal;
  } obs_t;

  typedef struct {
    logic        run;
    logic        rst;
    logic [5:0]  opcode;
    obs_t        exp;
    int unsigned cnt;
  } cyc_t;

  typedef struct {
    obs_t        exp;
    int unsigned cnt;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic run;
  logic [5:0] opcode;

  logic        ce4, rd4, rw4, as4, br4, mr4, mw4, m2r4, busy4, ill4;
  logic [3:0]  ret4;
  logic        ce32, rd32, rw32, as32, br32, mr32, mw32, m2r32, busy32, ill32;
  logic [31:0] ret32;

  cyc_t sched[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;

  // Reference model state used while building the schedule.
  int unsigned m_cnt;
  bit          m_ill_pend;

  always #5 clk = ~clk;

  mips_multicycle_control #(.CNT_WIDTH(4)) dut_w4 (
    .c_clk(clk), .c_rst(rst), .c_i_run(run), .c_i_opcode(opcode),
    .c_o_ce(ce4), .c_o_RegDst(rd4), .c_o_RegWrite(rw4), .c_o_ALUSrc(as4),
    .c_o_Branch(br4), .c_o_MemRead(mr4), .c_o_MemWrite(mw4),
    .c_o_MemtoReg(m2r4), .c_o_busy(busy4), .c_o_illegal(ill4),
    .c_o_retired(ret4)
  );

  mips_multicycle_control dut_w32 (
    .c_clk(clk), .c_rst(rst), .c_i_run(run), .c_i_opcode(opcode),
    .c_o_ce(ce32), .c_o_RegDst(rd32), .c_o_RegWrite(rw32), .c_o_ALUSrc(as32),
    .c_o_Branch(br32), .c_o_MemRead(mr32), .c_o_MemWrite(mw32),
    .c_o_MemtoReg(m2r32), .c_o_busy(busy32), .c_o_illegal(ill32),
    .c_o_retired(ret32)
  );

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {T_R, T_LW, T_SW, T_BEQ, T_ADDI};
  endfunction

  function automatic int latency(input logic [5:0] op);
    if (!legal(op))   return 2;
    if (op == T_BEQ)  return 3;
    if (op == T_LW)   return 5;
    return 4;
  endfunction

  task automatic push_cyc(input bit run_v, input bit rst_v,
                          input logic [5:0] op_v, input obs_t e);
    cyc_t c;
    c.run         = run_v;
    c.rst         = rst_v;
    c.opcode      = op_v;
    c.exp         = e;
    c.exp.illegal = m_ill_pend;
    c.cnt         = m_cnt;
    m_ill_pend    = 1'b0;
    sched.push_back(c);
  endtask

  task automatic emit_reset(input int n);
    m_cnt      = 0;
    m_ill_pend = 1'b0;
    for (int i = 0; i < n; i++) push_cyc(1'b1, 1'b1, 6'($urandom), '0);
  endtask

  // n idle cycles; only the last one may raise run to start fetching.
  task automatic emit_idle(input int n, input bit run_last);
    for (int i = 0; i < n; i++)
      push_cyc((i == n - 1) ? run_last : 1'b0, 1'b0, 6'($urandom), '0);
  endtask

  // One instruction. mid_run: 0/1 = fixed run after DECODE (1 before),
  // 2 = random run in non-final cycles. abort_at >= 0 replaces that cycle and
  // the rest with nothing (caller follows with a reset).
  task automatic emit_instr(input logic [5:0] op, input bit run_end,
                            input int mid_run, input int abort_at);
    int   len = latency(op);
    bit   ok  = legal(op);
    bit   imm = op inside {T_LW, T_SW, T_ADDI};
    bit   wr  = op inside {T_R, T_ADDI, T_LW};
    obs_t e;
    bit   r;
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) return;
      e      = '0;
      e.busy = 1'b1;
      e.ce   = (k == 0);
      if (ok) begin
        e.alu_src    = imm && (k >= 2);
        e.branch     = (op == T_BEQ) && (k == 2);
        e.mem_read   = (op == T_LW) && (k == 3);
        e.mem_write  = (op == T_SW) && (k == 3);
        e.reg_write  = wr && (k == len - 1);
        e.reg_dst    = e.reg_write && (op == T_R);
        e.mem_to_reg = e.reg_write && (op == T_LW);
      end
      if (k == len - 1)     r = run_end;
      else if (mid_run == 2) r = 1'($urandom);
      else                   r = (k < 2) ? 1'b1 : mid_run[0];
      push_cyc(r, 1'b0, (k == 1) ? op : 6'($urandom), e);
    end
    if (ok) m_cnt++;
    else    m_ill_pend = 1'b1;
  endtask

  task automatic build_program();
    logic [5:0] legal_ops [5];
    logic [5:0] op;
    bit         run_end;
    legal_ops = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI};
    m_cnt = 0;
    m_ill_pend = 1'b0;
    // Reset held with run=1, then release; FETCH follows the release cycle.
    emit_reset(3);
    emit_idle(1, 1'b1);
    emit_instr(T_R,    1'b1, 1, -1);
    emit_instr(T_LW,   1'b1, 1, -1);
    emit_instr(T_BEQ,  1'b1, 1, -1);
    emit_instr(T_SW,   1'b1, 1, -1);
    emit_instr(6'h3F,  1'b1, 1, -1);
    emit_instr(T_ADDI, 1'b1, 1, -1);
    // run drops in EXEC of a load: it still completes WB, then idles.
    emit_instr(T_LW,   1'b0, 0, -1);
    emit_idle(3, 1'b1);
    // Reset lands while a store is in MEM.
    emit_instr(T_SW,   1'b1, 1, 3);
    emit_reset(2);
    emit_idle(1, 1'b1);
    // Illegal opcode straight into an idle period.
    emit_instr(6'h3F,  1'b0, 1, -1);
    emit_idle(2, 1'b1);
    for (int n = 0; n < 220; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 4)];
      end
      if ($urandom_range(0, 39) == 0) begin
        emit_instr(op, 1'b1, 2, $urandom_range(0, latency(op) - 1));
        emit_reset($urandom_range(1, 2));
        emit_idle($urandom_range(1, 2), 1'b1);
      end else begin
        run_end = ($urandom_range(0, 3) != 0);
        emit_instr(op, run_end, 2, -1);
        if (!run_end) emit_idle($urandom_range(1, 3), 1'b1);
      end
    end
    emit_instr(T_R, 1'b0, 1, -1);
    emit_idle(3, 1'b0);
  endtask

  // Driver: apply one schedule entry per cycle, just after the rising edge.
  initial begin
    exp_t x;
    rst    = 1'b1;
    run    = 1'b0;
    opcode = '0;
    build_program();
    foreach (sched[i]) begin
      @(posedge clk);
      #1;
      rst    = sched[i].rst;
      run    = sched[i].run;
      opcode = sched[i].opcode;
      x.exp  = sched[i].exp;
      x.cnt  = sched[i].cnt;
      x.idx  = i;
      exp_q.push_back(x);
    end
    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", longint'(n_popped), longint'(sched.size()));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      obs_t o4, o32;
      x   = exp_q.pop_front();
      n_popped++;
      o4  = {ce4, rd4, rw4, as4, br4, mr4, mw4, m2r4, busy4, ill4};
      o32 = {ce32, rd32, rw32, as32, br32, mr32, mw32, m2r32, busy32, ill32};
      check($sformatf("ctrl_w4 cyc%0d", x.idx), longint'(o4), longint'(x.exp));
      check($sformatf("ctrl_w32 cyc%0d", x.idx), longint'(o32), longint'(x.exp));
      check($sformatf("retired_w4 cyc%0d", x.idx), longint'(ret4),
            longint'(x.cnt % 16));
      check($sformatf("retired_w32 cyc%0d", x.idx), longint'(ret32),
            longint'(x.cnt));
    end
  end

endmodule
